seg7_scan: RTL and testbench
============================

SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 SHALL have parameter DIV, default 50000, meaning CLK cycles per digit slot, legal range 2..2^20.
REQ-002 SHALL have port CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port DATA  input  32  ALU result word to display.
REQ-005 SHALL have port ZF  input  1  ALU zero flag.
REQ-006 SHALL have port OF  input  1  ALU overflow flag.
REQ-007 SHALL have port PAGE  input  1  0 = show DATA[15:0], 1 = show DATA[31:16].
REQ-008 SHALL have port HOLD  input  1  1 = freeze the displayed snapshot.
REQ-009 SHALL have port AN  output  4  digit enables, active-low, one-hot-low or all-high.
REQ-010 SHALL have port SEG  output  8  segments, active-low, bit order {dp,g,f,e,d,c,b,a}.

Function
REQ-011 SHALL run a prescaler counting 0..DIV-1 and wrapping to 0, asserting an internal tick in the cycle it equals DIV-1.
REQ-012 SHALL use two states: BLANK (after reset) and SCAN.
REQ-013 In BLANK, SHALL drive AN=4'b1111 and SEG=8'hFF; on the first tick, SHALL move to SCAN with digit index 0.
REQ-014 In SCAN, SHALL advance the 2-bit digit index on each tick: 0->1->2->3->0, wrapping without gaps.
REQ-015 SHALL drive AN registered, with AN[i]=0 only for the current digit i; AN and SEG SHALL change in the same cycle.
REQ-016 SHALL hold a frame snapshot {DATA, ZF, OF, PAGE}, loaded on each tick that enters digit 0 (including BLANK->SCAN) only when HOLD=0.
REQ-017 With HOLD=1 on a loading tick, the snapshot SHALL remain unchanged; scanning SHALL continue.
REQ-018 Input changes between loading ticks SHALL NOT affect the display; no tearing within a frame.
REQ-019 Digit i SHALL show the hex nibble i of the selected snapshot half: 0-9 and A,b,C,d,E,F glyphs.
REQ-020 SEG dp (bit 7) SHALL be 0 (lit) on digit 0 iff snapshot ZF=1, and on digit 1 iff snapshot OF=1; otherwise 1.
REQ-021 SEG dp SHALL be 1 on digits 2 and 3.
REQ-022 When a loading tick and HOLD rising coincide, the HOLD value of that cycle SHALL decide the load; HOLD=1 blocks it.
REQ-023 Frame period SHALL be exactly 4*DIV cycles; the first AN activity SHALL come DIV cycles after RST deassertion.

Reset
REQ-024 While RST=1 at a CLK edge, SHALL set the prescaler to 0, digit index to 0, state to BLANK, and snapshot to all-zero.
REQ-025 While RST=1 at a CLK edge, SHALL set AN=4'b1111 and SEG=8'hFF.
REQ-026 RST asserted mid-frame SHALL abort the scan at the next edge, with no partial digit afterwards.

Configuration
REQ-027 With macro SEG7_LEADING_BLANK_EN defined, digit i (i=1..3) SHALL be blanked when it and all higher nibbles of the selected half are zero.
REQ-028 A blanked digit SHALL have SEG[6:0]=7'h7F and AN still cycling; the dp rules of REQ-020 SHALL still apply.
REQ-029 Digit 0 SHALL never be blanked.
REQ-030 Without SEG7_LEADING_BLANK_EN, all four digits SHALL always show their nibble, including zeros.

Verification (DIV=4)
REQ-031 RST high 3 cycles, then low -> AN=1111, SEG=FF for 4 cycles; then AN=1110 showing nibble 0.
REQ-032 DATA=32'h1234ABCD, PAGE=0 -> over one frame, digits 0..3 show D,C,b,A with AN 1110,1101,1011,0111; the sequence repeats every 16 cycles.
REQ-033 DATA changes to 32'h00000005 mid-frame with PAGE=1 -> current frame unchanged; next frame shows 0000, or blank,blank,blank,0 with SEG7_LEADING_BLANK_EN.
REQ-034 HOLD=1 before a loading tick, then DATA changed -> display keeps the old snapshot; HOLD=0 -> new value from the next frame.
REQ-035 ZF=1, OF=1 latched -> dp lit on digits 0 and 1 only; ZF=0, OF=0 -> all dp off.
REQ-036 RST pulsed 1 cycle while digit 2 is active -> AN=1111 the next cycle; scan restarts at digit 0 DIV cycles later with snapshot 0.

Source files
------------

// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment scanner for a 32-bit ALU result with ZF/OF on the decimal points.
// Optional build macro SEG7_LEADING_BLANK_EN blanks leading zero digits 1..3.
module seg7_scan #(
  parameter int unsigned DIV = 50000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] DATA,
  input  logic        ZF,
  input  logic        OF,
  input  logic        PAGE,
  input  logic        HOLD,
  output logic [3:0]  AN,
  output logic [7:0]  SEG
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] data;
    logic        zf;
    logic        of;
    logic        page;
  } snap_t;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    dig_q, dig_d;
  snap_t         snap_q, snap_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick;
  logic [15:0]   half;
  logic [3:0]    nib;
  logic [6:0]    glyph;
  logic          blank;
  logic          dp_lit;

  assign tick = (cnt_q == CNT_MAX);

  // State, prescaler, snapshot and registered outputs
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= BLANK;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      snap_q  <= '0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= tick ? '0 : cnt_q + CW'(1);
      dig_q   <= dig_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
    end
  end

  // Next state: digit advance and frame snapshot load on entry to digit 0
  always_comb begin
    state_d = state_q;
    dig_d   = dig_q;
    snap_d  = snap_q;
    if (tick) begin
      case (state_q)
        BLANK: begin
          state_d = SCAN;
          dig_d   = 2'd0;
        end
        default: dig_d = dig_q + 2'd1;
      endcase
      if (dig_d == 2'd0 && !HOLD) begin
        snap_d = '{data: DATA, zf: ZF, of: OF, page: PAGE};
      end
    end
  end

  // Outputs computed from next-state values so AN and SEG register together
  always_comb begin
    half = snap_d.page ? snap_d.data[31:16] : snap_d.data[15:0];
    case (dig_d)
      2'd0:    nib = half[3:0];
      2'd1:    nib = half[7:4];
      2'd2:    nib = half[11:8];
      default: nib = half[15:12];
    endcase
    case (nib)
      4'h0: glyph = 7'h3F;
      4'h1: glyph = 7'h06;
      4'h2: glyph = 7'h5B;
      4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;
      4'h5: glyph = 7'h6D;
      4'h6: glyph = 7'h7D;
      4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;
      4'h9: glyph = 7'h6F;
      4'hA: glyph = 7'h77;
      4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;
      4'hD: glyph = 7'h5E;
      4'hE: glyph = 7'h79;
      default: glyph = 7'h71;
    endcase
`ifdef SEG7_LEADING_BLANK_EN
    case (dig_d)
      2'd1:    blank = (half[15:4] == 12'h000);
      2'd2:    blank = (half[15:8] == 8'h00);
      2'd3:    blank = (half[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
`else
    blank = 1'b0;
`endif
    dp_lit = (dig_d == 2'd0 && snap_d.zf) || (dig_d == 2'd1 && snap_d.of);
    an_d   = 4'hF;
    seg_d  = 8'hFF;
    if (state_d == SCAN) begin
      an_d  = ~(4'b0001 << dig_d);
      seg_d = {~dp_lit, blank ? 7'h7F : ~glyph};
    end
  end

  assign AN  = an_q;
  assign SEG = seg_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Scoreboard bench for seg7_scan at DIV=4: each loading tick pushes a frame of expected {AN,SEG}, each digit tick pops one.
module tb_seg7_scan;

  localparam int unsigned DIV = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] DATA;
  logic        ZF, OF, PAGE, HOLD;
  logic [3:0]  AN;
  logic [7:0]  SEG;

  seg7_scan #(.DIV(DIV)) dut (
    .CLK(CLK), .RST(RST), .DATA(DATA), .ZF(ZF), .OF(OF),
    .PAGE(PAGE), .HOLD(HOLD), .AN(AN), .SEG(SEG)
  );

  always #5 CLK = ~CLK;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [11:0] exp_q[$];
  logic [11:0] cur_exp = 12'hFFF;
  logic [34:0] m_snap  = '0;
  int unsigned e_cnt   = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: AN/SEG got %h expected %h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] glyph_n(input logic [3:0] n);
    case (n)
      4'h0: return 8'hC0;  4'h1: return 8'hF9;  4'h2: return 8'hA4;  4'h3: return 8'hB0;
      4'h4: return 8'h99;  4'h5: return 8'h92;  4'h6: return 8'h82;  4'h7: return 8'hF8;
      4'h8: return 8'h80;  4'h9: return 8'h90;  4'hA: return 8'h88;  4'hB: return 8'h83;
      4'hC: return 8'hC6;  4'hD: return 8'hA1;  4'hE: return 8'h86;  default: return 8'h8E;
    endcase
  endfunction

  // snapshot layout: {data[31:0], zf, of, page}
  function automatic logic [11:0] exp_digit(input logic [34:0] s, input int d);
    logic [15:0] h;
    logic [7:0]  sg;
    logic [3:0]  an;
    h  = s[0] ? s[34:19] : s[18:3];
    sg = glyph_n(4'((h >> (4 * d)) & 16'hF));
`ifdef SEG7_LEADING_BLANK_EN
    if (d > 0 && (h >> (4 * d)) == 16'h0) sg = 8'hFF;
`endif
    if ((d == 0 && s[2]) || (d == 1 && s[1])) sg[7] = 1'b0;
    an = 4'hF;
    an[d] = 1'b0;
    return {an, sg};
  endfunction

  // One clock: model consumes the inputs present before the edge, then compares after it
  task automatic step(input string tag);
    logic        r, h;
    logic [34:0] in_v;
    int unsigned m;
    r    = RST;
    h    = HOLD;
    in_v = {DATA, ZF, OF, PAGE};
    @(posedge CLK);
    #1;
    if (r) begin
      e_cnt   = 0;
      m_snap  = '0;
      exp_q.delete();
      cur_exp = 12'hFFF;
    end else begin
      e_cnt++;
      if (e_cnt % DIV == 0) begin
        m = e_cnt / DIV;
        if ((m - 1) % 4 == 0) begin
          if (!h) m_snap = in_v;
          for (int k = 0; k < 4; k++) exp_q.push_back(exp_digit(m_snap, k));
        end
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL %s: scoreboard empty at t=%0t", tag, $time);
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
    end
    check(tag, {AN, SEG}, cur_exp);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  initial begin
    RST = 1'b1; DATA = 32'h1234ABCD; ZF = 1'b0; OF = 1'b0; PAGE = 1'b0; HOLD = 1'b0;
    run("reset", 3);
    RST = 1'b0;
    run("first_blank", DIV);
    check("first_digit", {AN, SEG}, {4'b1110, 8'hA1});
    run("frame_abcd", 4 * DIV - 1);
    check("abcd_last", {AN, SEG}, {4'b0111, 8'h88});
    run("frame_abcd_rep", 4 * DIV);

    run("tear_pre", 6);
    DATA = 32'h00000005; PAGE = 1'b1;
    run("tear", 10 + 4 * DIV);

    DATA = 32'h89EF0000; ZF = 1'b1; OF = 1'b1;
    run("dp_on", 8 * DIV);
    ZF = 1'b0; OF = 1'b0;
    run("dp_off", 4 * DIV);

    HOLD = 1'b1;
    run("hold_a", 4 * DIV);
    DATA = 32'hC0DE7777;
    run("hold_b", 8 * DIV);
    HOLD = 1'b0;
    run("hold_rel", 8 * DIV);

    DATA = 32'h00000050; PAGE = 1'b0; ZF = 1'b1;
    run("lead_zero", 8 * DIV);

    // HOLD rises exactly on a loading tick together with new data
    while (((e_cnt + 1) % (4 * DIV)) != DIV) step("align");
    HOLD = 1'b1; DATA = 32'hFFFF0001; ZF = 1'b0;
    run("hold_edge", 8 * DIV);
    HOLD = 1'b0;
    run("hold_edge_rel", 8 * DIV);

    // reset pulse while digit 2 is active
    while (!(e_cnt >= DIV && e_cnt % DIV == 1 && ((e_cnt / DIV) - 1) % 4 == 2)) step("align2");
    RST = 1'b1;
    step("mid_rst");
    check("mid_rst_an", {AN, SEG}, 12'hFFF);
    RST = 1'b0;
    run("post_rst", 9 * DIV);

    for (int i = 0; i < 240; i++) begin
      if (i % 5 == 0) begin
        DATA = $urandom;
        {ZF, OF, PAGE} = 3'($urandom_range(0, 7));
        HOLD = ($urandom_range(0, 3) == 0);
      end
      step("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
